// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port arbiter in front of a single-ported synchronous memory. A CPU port
// and a debug/loader port compete for the memory; each access takes exactly
// one cycle from issue to ack. While one port is being acked, the other port
// may be issued in the same cycle, so two contending requesters alternate and
// keep the memory busy every cycle. A lone requester gets one access every
// two cycles, because its own request level is not looked at in its ack cycle.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata      CPU access request (level, held until cpu_ack)
//   cpu_ack, cpu_rdata         CPU completion pulse and read data
//   dbg_req/we/addr/wdata      debug/loader access request
//   dbg_ack, dbg_rdata         debug completion pulse and read data
//   mem_en, mem_we             memory strobe and write enable
//   mem_addr, mem_wdata        memory address and write data
//   mem_rdata                  memory read data (one cycle after a read strobe)
//   grant_dbg                  high while the access in flight is the debug one
//
// conflict_cnt is an internal 16-bit saturating count of cycles in which both
// ports were requesting and one of them had to wait.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  // debug/loader port
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  // memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // status
  output logic              grant_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_CPU = 2'd1,
    BUSY_DBG = 2'd2
  } state_t;

  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_DBG = 1'b1;

  state_t      state_reg;
  state_t      state_next;
  logic        last_grant_reg;   // port issued most recently
  logic        we_reg;           // in-flight access is a write
  logic        grant_dbg_reg;
  logic [15:0] conflict_cnt;
  logic [15:0] conflict_cnt_next;

  logic        issue_cpu;
  logic        issue_dbg;
  logic        conflict;

  // ---------------------------------------------------------------------------
  // Next-state, acks and read data. Everything is held inactive while reset is
  // asserted so the outputs drop to zero immediately, not at the next edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = IDLE;
    issue_cpu  = 1'b0;
    issue_dbg  = 1'b0;
    conflict   = 1'b0;
    cpu_ack    = 1'b0;
    dbg_ack    = 1'b0;
    cpu_rdata  = '0;
    dbg_rdata  = '0;

    if (!reset) begin
      unique case (state_reg)
        IDLE: begin
          if (cpu_req && dbg_req) begin
            // Tie: the port that did not win last time goes first.
            conflict = 1'b1;
            if (last_grant_reg == GRANT_DBG) begin
              issue_cpu = 1'b1;
            end else begin
              issue_dbg = 1'b1;
            end
          end else if (cpu_req) begin
            issue_cpu = 1'b1;
          end else if (dbg_req) begin
            issue_dbg = 1'b1;
          end
        end
        BUSY_CPU: begin
          // cpu_req still shows the access being completed, so only the
          // debug port is eligible for issue in this cycle.
          cpu_ack   = 1'b1;
          cpu_rdata = we_reg ? '0 : mem_rdata;
          issue_dbg = dbg_req;
        end
        BUSY_DBG: begin
          dbg_ack   = 1'b1;
          dbg_rdata = we_reg ? '0 : mem_rdata;
          issue_cpu = cpu_req;
        end
        default: begin
        end
      endcase

      if (issue_cpu) begin
        state_next = BUSY_CPU;
      end else if (issue_dbg) begin
        state_next = BUSY_DBG;
      end else begin
        state_next = IDLE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory request mux: driven straight from the issued port in the issue
  // cycle, all zero otherwise.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en    = issue_cpu | issue_dbg;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (issue_cpu) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (issue_dbg) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  always_comb begin
    conflict_cnt_next = conflict_cnt;
    if (conflict && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt_next = conflict_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers. last_grant resets to the debug port so the CPU wins the
  // first tie. The counter is written every cycle (hold or increment).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= GRANT_DBG;
      we_reg         <= 1'b0;
      grant_dbg_reg  <= 1'b0;
      conflict_cnt   <= 16'h0000;
    end else begin
      state_reg <= state_next;
      if (mem_en) begin
        last_grant_reg <= issue_dbg ? GRANT_DBG : GRANT_CPU;
        we_reg         <= mem_we;
      end
      grant_dbg_reg <= issue_dbg;
      conflict_cnt  <= conflict_cnt_next;
    end
  end

  assign grant_dbg = grant_dbg_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A synchronous memory model sits on the
// memory port; a transaction-level reference model (who is in flight, who is
// eligible, tie-break on the last winner) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_we, dbg_ack;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          mem_en, mem_we, grant_dbg;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic          cpu_ack;
    logic          dbg_ack;
    logic          grant_dbg;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] cpu_rdata;
    logic [DW-1:0] dbg_rdata;
  } obs_t;

  obs_t act;
  assign act = {cpu_ack, dbg_ack, grant_dbg, mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, dbg_rdata};

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant_dbg(grant_dbg)
  );

  always #5 clk = ~clk;

  // Synchronous memory on the arbiter's memory port.
  logic [DW-1:0] mem     [0:4095];
  logic [DW-1:0] ref_mem [0:4095];
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  // Reference model state: port in flight (0 none, 1 cpu, 2 dbg), its read
  // data, the last winner, the expected conflict count.
  int            m_inflight;
  int            m_issue;
  logic          m_last_dbg;
  logic [DW-1:0] m_rd;
  int            m_cnt;

  task automatic model_reset();
    m_inflight = 0;
    m_issue    = 0;
    m_last_dbg = 1'b1;
    m_rd       = '0;
    m_cnt      = 0;
  endtask

  // Expected outputs for the current cycle's inputs; advances the model past
  // the coming clock edge.
  task automatic model_cycle(output obs_t e);
    bit ce, de;
    e  = '0;
    ce = cpu_req && (m_inflight != 1);
    de = dbg_req && (m_inflight != 2);
    if (m_inflight == 1) begin
      e.cpu_ack = 1'b1; e.cpu_rdata = m_rd;
    end
    if (m_inflight == 2) begin
      e.dbg_ack = 1'b1; e.dbg_rdata = m_rd; e.grant_dbg = 1'b1;
    end
    m_issue = 0;
    if (ce && de) begin
      m_issue = m_last_dbg ? 1 : 2;
      if (m_cnt < 65535) m_cnt++;
    end else if (ce) begin
      m_issue = 1;
    end else if (de) begin
      m_issue = 2;
    end
    if (m_issue == 1) begin
      e.mem_en = 1'b1; e.mem_we = cpu_we; e.mem_addr = cpu_addr; e.mem_wdata = cpu_wdata;
    end else if (m_issue == 2) begin
      e.mem_en = 1'b1; e.mem_we = dbg_we; e.mem_addr = dbg_addr; e.mem_wdata = dbg_wdata;
    end
    if (m_issue != 0) begin
      m_last_dbg = (m_issue == 2);
      m_rd = e.mem_we ? '0 : ref_mem[e.mem_addr];
      if (e.mem_we) ref_mem[e.mem_addr] = e.mem_wdata;
    end
    m_inflight = m_issue;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; cpu_req = 1'b0; dbg_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_req = 1'b1; dbg_req = 1'b1;
    cpu_we = 1'b1; cpu_addr = 12'h3A5; cpu_wdata = 8'h5C;
    dbg_we = 1'b0; dbg_addr = 12'h0F0; dbg_wdata = 8'hC3;
    @(negedge clk); #1;
    checks++;
    if (act !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", act);
    end
    checks++;
    if (dut.conflict_cnt !== 16'h0000) begin
      errors++; $display("FAIL reset_conflict_cnt: got %h expected 0000", dut.conflict_cnt);
    end
    @(negedge clk);
    reset = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
    model_reset();
  endtask

  task automatic test_single_read();
    obs_t e;
    mem[12'h00C] = 8'h31; ref_mem[12'h00C] = 8'h31;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      cpu_req = (c < 2); cpu_we = 1'b0; cpu_addr = 12'h00C; cpu_wdata = DW'($urandom);
      #1; model_cycle(e);
      checks++;
      if (act !== e) begin
        errors++; $display("FAIL single_read c%0d: got %h expected %h", c, act, e);
      end
      if (c == 0) begin
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 12'h00C || cpu_ack !== 1'b0) begin
          errors++; $display("FAIL single_read_issue: mem_en=%b addr=%h ack=%b expected 1 00c 0", mem_en, mem_addr, cpu_ack);
        end
      end else if (c == 1) begin
        checks++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h31 || mem_en !== 1'b0) begin
          errors++; $display("FAIL single_read_ack: ack=%b rdata=%h mem_en=%b expected 1 31 0", cpu_ack, cpu_rdata, mem_en);
        end
      end
    end
  endtask

  task automatic test_tie();
    obs_t e;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      cpu_req = (c < 2); cpu_we = 1'b0; cpu_addr = 12'h0A0;
      dbg_req = (c < 2); dbg_we = 1'b0; dbg_addr = 12'h0B0;
      #1;
      checks++;
      if (dut.conflict_cnt !== 16'(m_cnt)) begin
        errors++; $display("FAIL tie_cnt c%0d: got %h expected %h", c, dut.conflict_cnt, 16'(m_cnt));
      end
      model_cycle(e);
      checks++;
      if (act !== e) begin
        errors++; $display("FAIL tie c%0d: got %h expected %h", c, act, e);
      end
    end
    checks++;
    if (dut.conflict_cnt !== 16'h0001) begin
      errors++; $display("FAIL tie_conflict_one: got %h expected 0001", dut.conflict_cnt);
    end
  endtask

  task automatic test_contention();
    obs_t e;
    int   prev_ack = 0;
    int   ack_port;
    logic cpu_acked = 1'b1;
    logic dbg_acked = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (c == 10) begin
        cpu_req = 1'b0; dbg_req = 1'b0;
      end else begin
        cpu_req = 1'b1; dbg_req = 1'b1;
        if (cpu_acked) begin
          cpu_we = 1'($urandom_range(0, 1)); cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
        end
        if (dbg_acked) begin
          dbg_we = 1'($urandom_range(0, 1)); dbg_addr = AW'($urandom); dbg_wdata = DW'($urandom);
        end
      end
      #1; model_cycle(e);
      checks++;
      if (act !== e) begin
        errors++; $display("FAIL contention c%0d: got %h expected %h", c, act, e);
      end
      checks++;
      if (mem_en !== (c < 10)) begin
        errors++; $display("FAIL contention_mem_en c%0d: got %b expected %b", c, mem_en, (c < 10));
      end
      if (c >= 1) begin
        ack_port = (cpu_ack === 1'b1) ? 1 : (dbg_ack === 1'b1) ? 2 : 0;
        checks++;
        if (ack_port == 0 || ack_port == prev_ack || (cpu_ack & dbg_ack) !== 1'b0) begin
          errors++; $display("FAIL contention_alternate c%0d: ack port %0d after %0d, required the other port", c, ack_port, prev_ack);
        end
        prev_ack = ack_port;
      end
      cpu_acked = cpu_ack;
      dbg_acked = dbg_ack;
    end
  endtask

  task automatic test_dbg_write_cpu_read();
    obs_t e;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      dbg_req = (c < 2); dbg_we = 1'b1; dbg_addr = 12'h123; dbg_wdata = 8'hA5;
      cpu_req = (c == 2 || c == 3); cpu_we = 1'b0; cpu_addr = 12'h123; cpu_wdata = 8'h00;
      #1; model_cycle(e);
      checks++;
      if (act !== e) begin
        errors++; $display("FAIL dbg_wr_cpu_rd c%0d: got %h expected %h", c, act, e);
      end
      if (c == 1) begin
        checks++;
        if (dbg_ack !== 1'b1 || dbg_rdata !== 8'h00 || grant_dbg !== 1'b1) begin
          errors++; $display("FAIL dbg_write_ack: ack=%b rdata=%h grant=%b expected 1 00 1", dbg_ack, dbg_rdata, grant_dbg);
        end
      end else if (c == 3) begin
        checks++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5) begin
          errors++; $display("FAIL cpu_read_back: ack=%b rdata=%h expected 1 a5", cpu_ack, cpu_rdata);
        end
      end
    end
  endtask

  task automatic test_random();
    obs_t e;
    bit hold[2];
    bit issued[2];
    hold[0] = 0; hold[1] = 0; issued[0] = 0; issued[1] = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (n >= 2998) begin
        hold[0] = 0; hold[1] = 0;
      end else begin
        if (hold[0] && !issued[0] && $urandom_range(0, 9) == 0) begin
          hold[0] = 0;
        end else if (!hold[0] && $urandom_range(0, 2) != 0) begin
          hold[0] = 1; issued[0] = 0;
          cpu_we = 1'($urandom_range(0, 1)); cpu_addr = AW'($urandom_range(0, 15)); cpu_wdata = DW'($urandom);
        end
        if (hold[1] && !issued[1] && $urandom_range(0, 9) == 0) begin
          hold[1] = 0;
        end else if (!hold[1] && $urandom_range(0, 2) != 0) begin
          hold[1] = 1; issued[1] = 0;
          dbg_we = 1'($urandom_range(0, 1)); dbg_addr = AW'($urandom_range(0, 15)); dbg_wdata = DW'($urandom);
        end
      end
      cpu_req = hold[0]; dbg_req = hold[1];
      #1;
      if (n % 100 == 0) begin
        checks++;
        if (dut.conflict_cnt !== 16'(m_cnt)) begin
          errors++; $display("FAIL random_cnt n%0d: got %h expected %h", n, dut.conflict_cnt, 16'(m_cnt));
        end
      end
      model_cycle(e);
      checks++;
      if (act !== e) begin
        errors++;
        if (errors < 30) $display("FAIL random n%0d: got %h expected %h", n, act, e);
      end
      if (m_issue == 1) issued[0] = 1;
      if (m_issue == 2) issued[1] = 1;
      if (e.cpu_ack) hold[0] = 0;
      if (e.dbg_ack) hold[1] = 0;
    end
  endtask

  task automatic test_reset_mid_access();
    obs_t e;
    @(negedge clk);
    cpu_req = 1'b0; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 12'h005;
    #1; model_cycle(e);
    checks++;
    if (act !== e || mem_en !== 1'b1) begin
      errors++; $display("FAIL rst_mid_issue: got %h expected %h", act, e);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (act !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: got %h expected 0", act);
    end
    checks++;
    if (dut.conflict_cnt !== 16'h0000) begin
      errors++; $display("FAIL rst_mid_cnt: got %h expected 0000", dut.conflict_cnt);
    end
    model_reset();
    @(negedge clk); #1;
    checks++;
    if (dbg_ack !== 1'b0 || act !== '0) begin
      errors++; $display("FAIL rst_mid_no_ack: got %h expected 0", act);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      reset = 1'b0; dbg_req = (c < 2);
      #1; model_cycle(e);
      checks++;
      if (act !== e) begin
        errors++; $display("FAIL rst_mid_rerequest c%0d: got %h expected %h", c, act, e);
      end
      if (c == 0) begin
        checks++;
        if (dbg_ack !== 1'b0 || mem_en !== 1'b1) begin
          errors++; $display("FAIL rst_mid_reissue: ack=%b mem_en=%b expected 0 1", dbg_ack, mem_en);
        end
      end
    end
  endtask

  task automatic test_saturation();
    obs_t e;
    for (int p = 0; p < 120; p++) begin
      if (p == 100) begin
        // Preload the counter near its ceiling with the requests idle.
        @(negedge clk);
        force dut.conflict_cnt = 16'hFFFB;
        @(negedge clk);
        release dut.conflict_cnt;
        m_cnt = 16'hFFFB;
      end
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        cpu_req = (c == 0); cpu_we = 1'b0; cpu_addr = AW'($urandom);
        dbg_req = (c == 0); dbg_we = 1'b0; dbg_addr = AW'($urandom);
        #1;
        if (c == 0) begin
          checks++;
          if (dut.conflict_cnt !== 16'(m_cnt)) begin
            errors++; $display("FAIL sat_cnt p%0d: got %h expected %h", p, dut.conflict_cnt, 16'(m_cnt));
          end
        end
        model_cycle(e);
        checks++;
        if (act !== e) begin
          errors++; $display("FAIL sat_traffic p%0d c%0d: got %h expected %h", p, c, act, e);
        end
      end
    end
    @(negedge clk); #1;
    checks++;
    if (dut.conflict_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat_final: got %h expected ffff", dut.conflict_cnt);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    model_reset();
    test_reset();
    test_single_read();
    test_tie();
    test_contention();
    test_dbg_write_cpu_read();
    test_random();
    test_reset_mid_access();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the memory address width in bits.
REQ-002 Parameter DATA_W, default 8, SHALL set the memory data width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 cpu_req  input  1  SHALL be the CPU access request, a level held until cpu_ack.
REQ-006 cpu_we  input  1  SHALL be the CPU write enable (1 = write, 0 = read), valid while cpu_req is high.
REQ-007 cpu_addr  input  ADDR_W  SHALL be the CPU address; cpu_wdata  input  DATA_W  SHALL be the CPU write data.
REQ-008 cpu_ack  output  1  SHALL be a one-cycle pulse marking completion of a CPU access; cpu_rdata  output  DATA_W  SHALL be the CPU read data.
REQ-009 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata SHALL be the debug/loader port, with the same directions, widths and meanings as the CPU port.
REQ-010 mem_en  output  1  SHALL be the memory access strobe; mem_we  output  1  SHALL be the memory write enable.
REQ-011 mem_addr  output  ADDR_W, mem_wdata  output  DATA_W  SHALL be the memory address and write data.
REQ-012 mem_rdata  input  DATA_W  SHALL be the memory read data, valid one cycle after mem_en with mem_we low (synchronous read).
REQ-013 grant_dbg  output  1  SHALL be high while the access in flight belongs to the debug port.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY_CPU and BUSY_DBG.
REQ-015 IDLE: if exactly one request is pending, that requester SHALL be issued and the FSM SHALL enter the matching BUSY state.
REQ-016 IDLE, both requests pending: the requester not granted most recently (last_grant register) SHALL be issued.
REQ-017 Issue cycle: mem_en=1; mem_we, mem_addr and mem_wdata SHALL be driven combinationally from the issued port.
REQ-018 BUSY_x: ack_x SHALL be 1 for exactly this cycle; rdata_x SHALL equal mem_rdata for a read and 0 for a write.
REQ-019 BUSY_x: the requester being acked SHALL NOT be re-sampled this cycle, because its request level still shows the completed access.
REQ-020 BUSY_x with the other port's request pending: the other port SHALL be issued in the same cycle and the FSM SHALL move to BUSY_y (back-to-back, one access per cycle).
REQ-021 BUSY_x with the other port idle: the FSM SHALL return to IDLE with mem_en=0.
REQ-022 A single requester therefore SHALL achieve at most one access per 2 cycles; two contending requesters SHALL alternate strictly, one access per cycle total.
REQ-023 Access latency SHALL be exactly 1 cycle from issue to ack; a request seen in IDLE SHALL be acked on the next cycle.
REQ-024 last_grant SHALL update on every issue to the issued port.
REQ-025 Outside an ack cycle: cpu_rdata=0, dbg_rdata=0, cpu_ack=0 and dbg_ack=0.
REQ-026 When mem_en=0: mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-027 A request that drops before it is issued SHALL be ignored; a request that drops after issue SHALL still complete and be acked.
REQ-028 Counter conflict_cnt (16 bits, internal, observable by the bench) SHALL increment on each cycle in which both requests are pending and one is denied, and SHALL saturate at 16'hFFFF.

Reset
REQ-029 Reset SHALL force asynchronously: state IDLE, last_grant = DBG (so CPU wins the first tie), conflict_cnt = 0 and grant_dbg = 0.
REQ-030 Reset SHALL drive all acks, rdata, mem_en, mem_we, mem_addr and mem_wdata to 0 while asserted.
REQ-031 Reset mid-access SHALL abort the in-flight access with no ack; the requester SHALL re-request after reset.

Verification
REQ-032 Single CPU read: cpu_req=1, cpu_we=0, cpu_addr=12'h00C, memory holds 8'h31 -> mem_en for 1 cycle with mem_addr=12'h00C; next cycle cpu_ack=1, cpu_rdata=8'h31.
REQ-033 Tie after reset: cpu_req and dbg_req rise together -> CPU issued first, DBG issued in the CPU ack cycle, acks on consecutive cycles, conflict_cnt=1.
REQ-034 Sustained contention: both requests held for 10 accesses -> grants strictly alternate, mem_en continuously high and no ack gaps.
REQ-035 Debug write then CPU read: dbg writes 8'hA5 to 12'h123, then cpu reads 12'h123 -> dbg_rdata=0 on the write ack; cpu_rdata=8'hA5.
REQ-036 Reset asserted in the BUSY_DBG issue cycle -> no dbg_ack, all outputs 0 immediately, state IDLE, conflict_cnt=0.
REQ-037 Saturation: force 70000 contended cycles -> conflict_cnt=16'hFFFF with no wrap.
